// File: rtl/pipelined_adder_module.sv
// Purpose: segmented carry-chain ADD/SUB/ADC/SBC unit with carry flag and status flags.
// Latency: issue at edge N -> result_valid after edge N+stages; one issue per cycle.
// Backpressure: result_valid && !result_ready freezes all stages and drops issue_ready;
//               ADC/SBC additionally wait until nothing is in flight ahead of them.
// Ports: selector0/1 pick an operand slot (0 = no issue), source0/1 hold packed candidates,
//        mode selects the operation, destination0..3 carry operand0, operand1, sum, flags.
module pipelined_adder_module #(
   parameter int width  = 16,
   parameter int stages = 2,
   parameter int count0 = 1,
   parameter int count1 = 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [$clog2(count0+1)-1:0] selector0,
   input  logic [$clog2(count1+1)-1:0] selector1,
   input  logic [count0*width-1:0]     source0,
   input  logic [count1*width-1:0]     source1,
   input  logic [1:0]                  mode,
   output logic                        issue_ready,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [width-1:0]            destination0,
   output logic [width-1:0]            destination1,
   output logic [width-1:0]            destination2,
   output logic [width-1:0]            destination3
);

   if (stages < 1 || stages > width || ((stages > 0) ? (width % stages) : 1) != 0) begin : g_bad_stages
      $error("pipelined_adder_module: stages=%0d is not legal for width=%0d", stages, width);
   end

   localparam int seg = (stages > 0) ? width / stages : width;

   typedef struct packed {
      logic             vld;
      logic [width-1:0] a;
      logic [width-1:0] b;     // operand1 as supplied, for destination1
      logic [width-1:0] beff;  // operand1 after the SUB/SBC inversion
      logic [width-1:0] sum;   // low slices filled in as the op moves down
      logic             cy;    // carry into the next slice
   } op_t;

   op_t              pipe [stages];  // pipe[k] is the input register of stage k
   op_t              nxt  [stages];  // pipe[k] with slice k resolved
   op_t              ent;
   op_t              fin;
   logic             carry_flag;
   logic             advance;
   logic             in_flight;
   logic             issue;
   logic [width-1:0] opnd0;
   logic [width-1:0] opnd1;
   logic [seg:0]     part;
   logic [3:0]       flag_bits;
   logic [width-1:0] flags_w;

   // Out-of-range selectors read as zero operands rather than aliasing a slot.
   always_comb begin
      opnd0 = '0;
      for (int i = 0; i < count0; i++) begin
         if (int'(selector0) == i + 1) opnd0 = source0[i*width +: width];
      end
      opnd1 = '0;
      for (int i = 0; i < count1; i++) begin
         if (int'(selector1) == i + 1) opnd1 = source1[i*width +: width];
      end
   end

   assign advance = !result_valid || result_ready;

   always_comb begin
      in_flight = 1'b0;
      for (int k = 0; k < stages; k++) in_flight = in_flight | pipe[k].vld;
   end

   // ADC/SBC sample the carry flag at issue, so every older op must already
   // have loaded the output register; advance covers the output side.
   assign issue_ready = advance && (!mode[1] || !in_flight);
   assign issue       = issue_ready && (selector0 != '0) && (selector1 != '0);

   always_comb begin
      ent      = '0;
      ent.vld  = issue;
      ent.a    = opnd0;
      ent.b    = opnd1;
      ent.beff = mode[0] ? ~opnd1 : opnd1;
      ent.cy   = mode[1] ? carry_flag : mode[0];
   end

   always_comb begin
      part = '0;
      for (int k = 0; k < stages; k++) begin
         nxt[k] = pipe[k];
         part   = {1'b0, pipe[k].a[k*seg +: seg]} + {1'b0, pipe[k].beff[k*seg +: seg]}
                + {{seg{1'b0}}, pipe[k].cy};
         nxt[k].sum[k*seg +: seg] = part[seg-1:0];
         nxt[k].cy                = part[seg];
      end
   end

   assign fin = nxt[stages-1];

   always_comb begin
      flag_bits[0] = fin.cy;
      flag_bits[1] = (fin.sum == '0);
      flag_bits[2] = (fin.a[width-1] == fin.beff[width-1]) && (fin.sum[width-1] != fin.a[width-1]);
      flag_bits[3] = fin.sum[width-1];
      flags_w      = width'(flag_bits);
   end

   // Destinations only load on a valid result so they keep the last value after retirement.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < stages; k++) pipe[k] <= '0;
         result_valid <= 1'b0;
         destination0 <= '0;
         destination1 <= '0;
         destination2 <= '0;
         destination3 <= '0;
         carry_flag   <= 1'b0;
      end else if (advance) begin
         pipe[0] <= ent;
         for (int k = 1; k < stages; k++) pipe[k] <= nxt[k-1];
         result_valid <= fin.vld;
         if (fin.vld) begin
            destination0 <= fin.a;
            destination1 <= fin.b;
            destination2 <= fin.sum;
            destination3 <= flags_w;
            carry_flag   <= fin.cy;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_module.sv
module tb_pipelined_adder_module;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] ADC = 2'b10;
   localparam logic [1:0] SBC = 2'b11;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  selector0;
   logic [0:0]  selector1;
   logic [31:0] source0;
   logic [15:0] source1;
   logic [1:0]  mode;
   logic        issue_ready;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] destination0;
   logic [15:0] destination1;
   logic [15:0] destination2;
   logic [15:0] destination3;

   pipelined_adder_module #(.width(16), .stages(2), .count0(2), .count1(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .selector0(selector0), .selector1(selector1),
      .source0(source0), .source1(source1), .mode(mode),
      .issue_ready(issue_ready), .result_valid(result_valid), .result_ready(result_ready),
      .destination0(destination0), .destination1(destination1),
      .destination2(destination2), .destination3(destination3)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum;
      logic [15:0] flags;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: every retiring result is checked against the oldest expectation.
   always @(negedge clock) begin
      if (reset_n && result_valid && result_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result: got sum=%h flags=%h, expected no result", destination2, destination3);
         end else begin
            mon_e = exp_q.pop_front();
            if ({destination0, destination1, destination2, destination3} !== mon_e) begin
               n_bad++;
               $display("FAIL result: got a=%h b=%h sum=%h flags=%h, expected a=%h b=%h sum=%h flags=%h",
                        destination0, destination1, destination2, destination3,
                        mon_e.a, mon_e.b, mon_e.sum, mon_e.flags);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called and returns at posedge+1; holds the request until issue_ready is seen.
   task automatic do_issue(input logic [1:0] s0, input logic [31:0] src0, input logic [15:0] src1,
                           input logic [1:0] md, input logic [15:0] ea, input logic [15:0] esum,
                           input logic [15:0] eflags, input bit track, output int waited);
      selector0 = s0;
      selector1 = 1'b1;
      source0   = src0;
      source1   = src1;
      mode      = md;
      waited    = 0;
      @(negedge clock);
      while (!issue_ready && waited < 40) begin
         @(negedge clock);
         waited++;
      end
      if (!issue_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout: issue_ready 0 after %0d cycles, expected 1", waited);
      end else if (track) begin
         exp_q.push_back({ea, src1, esum, eflags});
      end
      @(posedge clock);
      #1;
      selector0 = '0;
      selector1 = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || result_valid) && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || result_valid) begin
         n_bad++;
         $display("FAIL %s: %0d results outstanding, valid=%0b, expected 0 and 0", name, exp_q.size(), result_valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int w;
      reset_n = 1'b0; selector0 = '0; selector1 = '0; source0 = '0; source1 = '0;
      mode = ADD; result_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_valid", 32'(result_valid), 32'h0);
      check("reset_dst0", 32'(destination0), 32'h0);
      check("reset_dst2", 32'(destination2), 32'h0);
      check("reset_dst3", 32'(destination3), 32'h0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Latency and hold after retirement.
      do_issue(2'd1, 32'h0000_00FF, 16'h0001, ADD, 16'h00FF, 16'h0100, 16'h0000, 1'b1, w);
      check("add_wait", 32'(w), 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check($sformatf("latency_c%0d", c), 32'(result_valid), (c == 2) ? 32'h1 : 32'h0);
      end
      check("hold_dst2", 32'(destination2), 32'h0100);
      check("hold_dst0", 32'(destination0), 32'h00FF);
      @(posedge clock); #1;

      // Subtract and overflow vectors, back to back.
      do_issue(2'd1, 32'h0000_0005, 16'h0005, SUB, 16'h0005, 16'h0000, 16'h0003, 1'b1, w);
      do_issue(2'd1, 32'h0000_0000, 16'h0001, SUB, 16'h0000, 16'hFFFF, 16'h0008, 1'b1, w);
      do_issue(2'd1, 32'h0000_7FFF, 16'h0001, ADD, 16'h7FFF, 16'h8000, 16'h000C, 1'b1, w);
      do_issue(2'd1, 32'h0000_8000, 16'h0001, SUB, 16'h8000, 16'h7FFF, 16'h0005, 1'b1, w);
      wait_idle("drain_arith");

      // Slot selection, out-of-range slot, single selector.
      do_issue(2'd2, 32'h0123_FFFF, 16'h0001, ADD, 16'h0123, 16'h0124, 16'h0000, 1'b1, w);
      do_issue(2'd3, 32'hAAAA_5555, 16'h1234, ADD, 16'h0000, 16'h1234, 16'h0000, 1'b1, w);
      selector0 = 2'd1; selector1 = 1'b0; source0 = 32'h0000_1111;
      repeat (3) @(posedge clock);
      #1;
      selector0 = 2'd0; selector1 = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      selector1 = 1'b0;
      wait_idle("drain_select");

      // ADC hazard: carry from the preceding ADD.
      do_issue(2'd1, 32'h0000_FFFF, 16'h0001, ADD, 16'hFFFF, 16'h0000, 16'h0003, 1'b1, w);
      do_issue(2'd1, 32'h0000_0000, 16'h0000, ADC, 16'h0000, 16'h0001, 16'h0000, 1'b1, w);
      check("adc_hazard_wait", 32'(w), 32'h2);
      // 0x12348001 + 0x43218000 = 0x55560001
      do_issue(2'd1, 32'h0000_8001, 16'h8000, ADD, 16'h8001, 16'h0001, 16'h0005, 1'b1, w);
      do_issue(2'd1, 32'h0000_1234, 16'h4321, ADC, 16'h1234, 16'h5556, 16'h0000, 1'b1, w);
      check("adc_chain_wait", 32'(w), 32'h2);
      // 0x00010000 - 0x00000001 = 0x0000FFFF
      do_issue(2'd1, 32'h0000_0000, 16'h0001, SUB, 16'h0000, 16'hFFFF, 16'h0008, 1'b1, w);
      do_issue(2'd1, 32'h0000_0001, 16'h0000, SBC, 16'h0001, 16'h0000, 16'h0003, 1'b1, w);
      check("sbc_chain_wait", 32'(w), 32'h2);
      wait_idle("drain_chain");

      // Back-to-back with a three-cycle stall.
      do_issue(2'd1, 32'h0000_1111, 16'h0001, ADD, 16'h1111, 16'h1112, 16'h0000, 1'b1, w);
      check("b2b_wait0", 32'(w), 32'h0);
      do_issue(2'd1, 32'h0000_2222, 16'h2222, ADD, 16'h2222, 16'h4444, 16'h0000, 1'b1, w);
      check("b2b_wait1", 32'(w), 32'h0);
      do_issue(2'd1, 32'h0000_8000, 16'h8000, ADD, 16'h8000, 16'h0000, 16'h0007, 1'b1, w);
      check("b2b_wait2", 32'(w), 32'h0);
      do_issue(2'd1, 32'h0000_F0F0, 16'h0F10, ADD, 16'hF0F0, 16'h0000, 16'h0003, 1'b1, w);
      check("b2b_wait3", 32'(w), 32'h0);
      result_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check($sformatf("stall_ready_c%0d", c), 32'(issue_ready), 32'h0);
         @(posedge clock); #1;
      end
      result_ready = 1'b1;
      @(negedge clock);
      check("unstall_ready", 32'(issue_ready), 32'h1);
      @(posedge clock); #1;
      wait_idle("drain_stall");

      // Reset with two ops in flight; carry flag is set beforehand.
      do_issue(2'd1, 32'h0000_FFFF, 16'h0002, ADD, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, w);
      wait_idle("drain_pre_reset");
      do_issue(2'd1, 32'h0000_1111, 16'h0001, ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0, w);
      do_issue(2'd1, 32'h0000_2222, 16'h0001, ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0, w);
      result_ready = 1'b0;
      @(posedge clock); #1;
      check("pre_reset_valid", 32'(result_valid), 32'h1);
      reset_n = 1'b0;
      #1;
      check("mid_reset_valid", 32'(result_valid), 32'h0);
      check("mid_reset_dst0", 32'(destination0), 32'h0);
      check("mid_reset_dst1", 32'(destination1), 32'h0);
      check("mid_reset_dst2", 32'(destination2), 32'h0);
      check("mid_reset_dst3", 32'(destination3), 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      result_ready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("post_reset_valid", 32'(result_valid), 32'h0);
      do_issue(2'd1, 32'h0000_0000, 16'h0000, ADC, 16'h0000, 16'h0000, 16'h0002, 1'b1, w);
      check("post_reset_adc_wait", 32'(w), 32'h0);
      wait_idle("drain_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_module.md
Name: pipelined_adder_module

Overview:
- Parametrised successor to the single-cycle adder module; a segmented, pipelined carry-chain adder.
- Selects one operand from each of two source buses and supports four arithmetic modes, including carry-chained multi-word add and subtract.
- Adds an architectural carry flag, status flags and a valid/ready result handshake.
- Sits on the datapath bus as a functional unit; destinations feed the destination bus like other modules.

Parameters:
- width, 16, operand/result width in bits.
- stages, 2, pipeline depth; each stage resolves width/stages bits. Legal values: 1..width with width % stages == 0; illegal values must fail elaboration.
- count0, 1, number of width-bit sources on source0.
- count1, 1, number of width-bit sources on source1.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- selector0  input  $clog2(count0+1)  0 = no issue; k = source0 slot k-1.
- selector1  input  $clog2(count1+1)  0 = no issue; k = source1 slot k-1.
- source0  input  count0*width  packed operand-0 candidates; slot 0 in the LSBs.
- source1  input  count1*width  packed operand-1 candidates.
- mode  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- issue_ready  output  1  high when an issue is accepted this cycle.
- result_valid  output  1  result on destination0..3 is valid.
- result_ready  input  1  consumer accepts the result.
- destination0  output  width  operand0 of the presented result.
- destination1  output  width  operand1 of the presented result, as supplied (not inverted).
- destination2  output  width  sum/difference.
- destination3  output  width  flags, zero-extended: [0] carry, [1] zero, [2] overflow, [3] negative.

Behaviour:
- Reset (async assert, sync-safe release): all pipeline valid bits, result_valid, destination0..3 and the carry flag go to 0.
- Issue: occurs when both selectors are nonzero and issue_ready is high; selectors, sources and mode are sampled on that edge.
  - Exactly one selector nonzero: no issue, no side effects.
  - Selector greater than count: the operand is 0.
- Operation:
  - b_eff = operand1 for ADD/ADC; ~operand1 for SUB/SBC.
  - carry_in = 0 (ADD), 1 (SUB), carry flag (ADC, SBC).
  - Sum computed modulo 2^width.
  - carry = carry-out of the top bit. For SUB/SBC, carry=1 means no borrow.
  - overflow = signed overflow: operand0 and b_eff have equal signs and the sum sign differs.
  - zero = (sum == 0). negative = sum[width-1].
- Pipeline:
  - Stage k adds bits [k*seg +: seg], where seg = width/stages, using the carry registered from stage k-1.
  - Upper operand slices and the sum's low slices travel with the operation.
  - Latency: an issue at edge N gives result_valid high after edge N+stages.
  - Throughput: 1 per cycle.
- Stall: advance = !result_valid | result_ready.
  - When advance is low, every stage holds and issue_ready is low.
  - Bubbles are not compressed.
- Carry flag: updated with the result's carry on the edge where the output register is loaded with a valid op of any mode.
- ADC/SBC hazard: issue_ready for mode 1x additionally requires all internal stages and the output register to be empty, or the output to be retiring this cycle with no other op in flight.
  - ADC/SBC therefore always sees the carry of the previous op.
  - ADD/SUB never wait for the hazard.
- Retirement: on an edge with result_valid && result_ready:
  - If a new result arrives the same edge, it replaces the outputs and result_valid stays 1.
  - Otherwise result_valid drops to 0 and destination0..3 hold their last values.
- Reset mid-operation: in-flight ops are discarded and the carry flag is cleared; nothing is produced after reset releases.
- stages=1 degenerates to a registered single-cycle adder with the same handshake.

Test Plan:
- width=16, stages=2, result_ready=1: ADD 0x00FF+0x0001 at cycle 0 -> result_valid at cycle 2; destination2=0x0100; flags=0x0.
- SUB 0x0005-0x0005 -> sum 0x0000, flags=0x3 (carry, zero). SUB 0x0000-0x0001 -> sum 0xFFFF, flags=0x8.
- ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 issued the next cycle:
  - issue_ready is low until the ADD has retired.
  - ADC result = 0x0001; the 32-bit multi-word chain is correct.
- Signed overflow: ADD 0x7FFF+0x0001 -> 0x8000, flags=0xC. SUB 0x8000-0x0001 -> 0x7FFF, flags=0x5.
- Back-to-back: 4 ADDs on consecutive cycles with result_ready held low from cycle 3 for 3 cycles:
  - Results are not lost or duplicated and retire in order.
  - issue_ready is low exactly while stalled.
- Assert reset_n low with 2 ops in flight:
  - result_valid=0 and destinations=0 immediately.
  - No result after release; the following ADC uses carry_in=0.
